// File: rtl/product_acc_pkg.sv
// ---------------------------------------------------------------------------
// product_acc_pkg
// Shared definitions for the product accumulator:
//   - state_t      : accumulator FSM state (IDLE, ACCUM, DONE), 2-bit encoding
//   - *_DEF        : default widths and frame length limit
// No ports (package).
// ---------------------------------------------------------------------------
package product_acc_pkg;

   localparam int PROD_W_DEF    = 8;   // multiplier product width
   localparam int ACC_W_DEF     = 12;  // accumulator / result width
   localparam int MAX_TERMS_DEF = 32;  // beats per frame before forced end
   localparam int CNT_W_DEF     = 6;   // term counter width (2^CNT_W > MAX_TERMS)

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : product_acc_pkg

// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_accumulator_if
// Bundles the product input handshake and the frame result handshake.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. The source keeps its payload stable
// while valid is high and ready is low; ready may be asserted before valid
// without effect.
//
// Signals:
//   in_valid, product[PROD_W], in_last   producer -> accumulator
//   in_ready                             accumulator -> producer
//   out_valid, sum[ACC_W], count[CNT_W],
//   overflow, forced                     accumulator -> consumer
//   out_ready                            consumer -> accumulator
// Modports: slave (the accumulator), master (the surrounding environment).
// ---------------------------------------------------------------------------
interface product_accumulator_if #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 12,
   parameter int CNT_W  = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] product;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  sum;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              forced;

   modport slave (
      input  in_valid, product, in_last, out_ready,
      output in_ready, out_valid, sum, count, overflow, forced
   );

   modport master (
      output in_valid, product, in_last, out_ready,
      input  in_ready, out_valid, sum, count, overflow, forced
   );

endinterface : product_accumulator_if

// File: rtl/product_accumulator_acc_add.sv
// ---------------------------------------------------------------------------
// acc_add
// Combinational accumulator adder: i_acc + zero-extended i_product computed
// ACC_W+1 bits wide so the carry out is visible.
// Optional macro PRODUCT_ACCUMULATOR_SATURATE_EN: when defined, a carry
// clamps the result to all ones; otherwise the result wraps modulo 2^ACC_W.
// Ports:
//   i_acc     [ACC_W]   current accumulator value
//   i_product [PROD_W]  unsigned product to add
//   o_acc     [ACC_W]   next accumulator value
//   o_carry   [1]       carry out of the ACC_W-bit add
// ---------------------------------------------------------------------------
module acc_add #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 12
) (
   input  logic [ACC_W-1:0]  i_acc,
   input  logic [PROD_W-1:0] i_product,
   output logic [ACC_W-1:0]  o_acc,
   output logic              o_carry
);

   logic [ACC_W:0] w_sum;
   logic           w_carry;

   // Cast zero-extends the unsigned product; safe even when ACC_W == PROD_W.
   assign w_sum   = {1'b0, i_acc} + (ACC_W+1)'(i_product);
   assign w_carry = w_sum[ACC_W];
   assign o_carry = w_carry;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
   // Once clamped, any later non-zero product carries again, so the value
   // stays pinned at all ones for the rest of the frame.
   assign o_acc = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
   assign o_acc = w_sum[ACC_W-1:0];
`endif

endmodule : acc_add

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Sums a frame of unsigned multiplier products into an ACC_W accumulator and
// presents the frame result on an output handshake. A frame ends on in_last
// or after MAX_TERMS accepted beats (forced). in_last wins when both occur.
// Optional macro PRODUCT_ACCUMULATOR_SATURATE_EN selects saturating rather
// than wrapping accumulation (implemented in acc_add).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   bus          product_accumulator_if.slave (both handshakes + results)
//   o_dbg_state  current FSM state, for observation only
// ---------------------------------------------------------------------------
module product_accumulator
   import product_acc_pkg::*;
#(
   parameter int PROD_W    = PROD_W_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int MAX_TERMS = MAX_TERMS_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   product_accumulator_if.slave bus,
   output state_t               o_dbg_state
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   state_t           r_state, w_state_nxt;
   logic [ACC_W-1:0] r_acc, w_acc_nxt, w_acc_base, w_add_acc;
   logic             w_add_carry;
   logic [CNT_W-1:0] r_count, w_count_nxt, w_count_inc;
   logic             r_overflow, w_overflow_nxt;
   logic             r_forced, w_forced_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic             r_in_ready, w_in_ready_nxt;
   logic             w_accept;

   assign w_accept = bus.in_valid & r_in_ready;

   // The first beat of a frame starts from zero regardless of stale values.
   assign w_acc_base  = (r_state == IDLE) ? '0 : r_acc;
   assign w_count_inc = ((r_state == IDLE) ? '0 : r_count) + CNT_W'(1);

   acc_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_acc_add (
      .i_acc     (w_acc_base),
      .i_product (bus.product),
      .o_acc     (w_add_acc),
      .o_carry   (w_add_carry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_forced    <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_count     <= w_count_nxt;
         r_overflow  <= w_overflow_nxt;
         r_forced    <= w_forced_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_in_ready  <= w_in_ready_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_count_nxt     = r_count;
      w_overflow_nxt  = r_overflow;
      w_forced_nxt    = r_forced;
      w_out_valid_nxt = r_out_valid;
      w_in_ready_nxt  = r_in_ready;

      unique case (r_state)
         IDLE, ACCUM: begin
            // in_ready is registered low right after reset; raise it here so
            // the block becomes ready on the first clock after release.
            w_in_ready_nxt = 1'b1;
            if (w_accept) begin
               w_acc_nxt      = w_add_acc;
               w_count_nxt    = w_count_inc;
               w_overflow_nxt = r_overflow | w_add_carry;
               if (bus.in_last) begin
                  w_state_nxt     = DONE;
                  w_forced_nxt    = 1'b0;
                  w_out_valid_nxt = 1'b1;
                  w_in_ready_nxt  = 1'b0;
               end else if (w_count_inc == MAX_CNT) begin
                  w_state_nxt     = DONE;
                  w_forced_nxt    = 1'b1;
                  w_out_valid_nxt = 1'b1;
                  w_in_ready_nxt  = 1'b0;
               end else begin
                  w_state_nxt = ACCUM;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_state_nxt     = IDLE;
               w_acc_nxt       = '0;
               w_count_nxt     = '0;
               w_overflow_nxt  = 1'b0;
               w_forced_nxt    = 1'b0;
               w_out_valid_nxt = 1'b0;
               w_in_ready_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_acc_nxt       = '0;
            w_count_nxt     = '0;
            w_overflow_nxt  = 1'b0;
            w_forced_nxt    = 1'b0;
            w_out_valid_nxt = 1'b0;
            w_in_ready_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.sum       = r_acc;
   assign bus.count     = r_count;
   assign bus.overflow  = r_overflow;
   assign bus.forced    = r_forced;
   assign o_dbg_state   = r_state;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
// Self-checking bench for product_accumulator: reset, fixed frame table,
// hand-written corner sequences and random frames against a sum model.
// Honours PRODUCT_ACCUMULATOR_SATURATE_EN for the expected frame sums.
// ---------------------------------------------------------------------------
module tb_product_accumulator;
   import product_acc_pkg::*;

   localparam int PROD_W    = 8;
   localparam int ACC_W     = 12;
   localparam int CNT_W     = 6;
   localparam int MAX_TERMS = 32;
   localparam int ACC_MAX   = (1 << ACC_W) - 1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   reset;
   state_t dbg_state;
   int     checks   = 0;
   int     failures = 0;

   always #5 clk = ~clk;

   product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   product_accumulator #(
      .PROD_W    (PROD_W),
      .ACC_W     (ACC_W),
      .MAX_TERMS (MAX_TERMS),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard helpers ----------------
   typedef struct {
      int         n;
      logic [7:0] val;
      bit         use_last;
      int         gap;
      int         sum;
      int         cnt;
      bit         ovf;
      bit         frc;
   } vec_t;

   vec_t       vecs[8];
   logic [7:0] frame_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Frame sum from the arithmetic rules: plain total, then wrap or clamp.
   function automatic int model_sum(input int total);
      if (SAT) return (total > ACC_MAX) ? ACC_MAX : total;
      return total % (ACC_MAX + 1);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_beat(input logic [7:0] p, input bit last, input int gap);
      int waited;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
      end
      @(negedge clk);
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 20) begin
         bus.in_valid = 1'b0;
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) begin
         checks++;
         failures++;
         $display("FAIL in_ready_wait actual=0 required=1");
      end
      bus.in_valid = 1'b1;
      bus.product  = p;
      bus.in_last  = last;
      @(posedge clk);
   endtask

   task automatic send_frame(input bit use_last, input int gap);
      for (int i = 0; i < frame_q.size(); i++)
         drive_beat(frame_q[i], use_last && (i == frame_q.size() - 1), (i == 0) ? 0 : gap);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Waits for the result, checks it, holds it for 'hold' cycles (optionally
   // with input beats offered), then releases it and checks the return to IDLE.
   task automatic finish_frame(input string name, input int e_sum, input int e_cnt,
                               input bit e_ovf, input bit e_frc, input int hold, input bit spam);
      int waited = 0;
      while (bus.out_valid !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, "_sum"},       32'(bus.sum),       32'(e_sum));
      check({name, "_count"},     32'(bus.count),     32'(e_cnt));
      check({name, "_overflow"},  32'(bus.overflow),  32'(e_ovf));
      check({name, "_forced"},    32'(bus.forced),    32'(e_frc));
      check({name, "_in_ready"},  32'(bus.in_ready),  32'd0);
      for (int h = 0; h < hold; h++) begin
         if (spam) begin
            bus.in_valid = 1'b1;
            bus.product  = 8'($urandom_range(1, 255));
            bus.in_last  = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         check({name, "_hold_sum"},      32'(bus.sum),       32'(e_sum));
         check({name, "_hold_count"},    32'(bus.count),     32'(e_cnt));
         check({name, "_hold_valid"},    32'(bus.out_valid), 32'd1);
         check({name, "_hold_in_ready"}, 32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({name, "_rel_valid"},    32'(bus.out_valid), 32'd0);
      check({name, "_rel_in_ready"}, 32'(bus.in_ready),  32'd1);
      check({name, "_rel_count"},    32'(bus.count),     32'd0);
      check({name, "_rel_sum"},      32'(bus.sum),       32'd0);
      check({name, "_rel_overflow"}, 32'(bus.overflow),  32'd0);
      check({name, "_rel_forced"},   32'(bus.forced),    32'd0);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{n: 19, val: 8'd225, use_last: 1, gap: 0,
                  sum: SAT ? 4095 : 179, cnt: 19, ovf: 1, frc: 0};
      vecs[1] = '{n: 32, val: 8'd1,   use_last: 0, gap: 0, sum: 32, cnt: 32, ovf: 0, frc: 1};
      vecs[2] = '{n: 32, val: 8'd1,   use_last: 1, gap: 0, sum: 32, cnt: 32, ovf: 0, frc: 0};
      vecs[3] = '{n: 1,  val: 8'h51,  use_last: 1, gap: 0, sum: 81, cnt: 1,  ovf: 0, frc: 0};
      vecs[4] = '{n: 3,  val: 8'd7,   use_last: 1, gap: 2, sum: 21, cnt: 3,  ovf: 0, frc: 0};
      vecs[5] = '{n: 16, val: 8'd255, use_last: 1, gap: 1, sum: 4080, cnt: 16, ovf: 0, frc: 0};
      vecs[6] = '{n: 17, val: 8'd255, use_last: 1, gap: 0,
                  sum: SAT ? 4095 : 239, cnt: 17, ovf: 1, frc: 0};
      vecs[7] = '{n: 1,  val: 8'd0,   use_last: 1, gap: 0, sum: 0, cnt: 1, ovf: 0, frc: 0};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.product   = '0;
      bus.out_ready = 1'b1;   // ready before valid must have no effect
      repeat (3) @(negedge clk);
      check("rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sum",       32'(bus.sum),       32'd0);
      check("rst_count",     32'(bus.count),     32'd0);
      check("rst_overflow",  32'(bus.overflow),  32'd0);
      check("rst_forced",    32'(bus.forced),    32'd0);
      check("rst_state",     32'(dbg_state),     32'(IDLE));
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b0;

      // Reset in the middle of a frame clears everything at once.
      for (int i = 0; i < 3; i++) drive_beat(8'd225, 1'b0, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("mid_partial_sum",   32'(bus.sum),   32'd675);
      check("mid_partial_count", 32'(bus.count), 32'd3);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_sum",       32'(bus.sum),       32'd0);
      check("mid_rst_count",     32'(bus.count),     32'd0);
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Normal frame with 5 cycles of backpressure and beats offered in DONE.
      frame_q = '{8'd225, 8'd9, 8'd0, 8'd4};
      send_frame(1'b1, 0);
      finish_frame("normal", 238, 4, 1'b0, 1'b0, 5, 1'b1);

      // Table of constant-valued frames.
      foreach (vecs[v]) begin
         frame_q.delete();
         for (int i = 0; i < vecs[v].n; i++) frame_q.push_back(vecs[v].val);
         send_frame(vecs[v].use_last, vecs[v].gap);
         finish_frame($sformatf("vec%0d", v), vecs[v].sum, vecs[v].cnt,
                      vecs[v].ovf, vecs[v].frc, v % 3, 1'b0);
      end

      // Random frames against the arithmetic model.
      for (int f = 0; f < 24; f++) begin
         bit has_last;
         int n, total, hi;
         has_last = ($urandom_range(0, 3) != 0);
         n        = has_last ? int'($urandom_range(1, MAX_TERMS)) : MAX_TERMS;
         hi       = (f % 2 == 0) ? 255 : 60;
         total    = 0;
         frame_q.delete();
         for (int i = 0; i < n; i++) begin
            logic [7:0] p;
            p = 8'($urandom_range(0, hi));
            frame_q.push_back(p);
            total += int'(p);
         end
         send_frame(has_last, $urandom_range(0, 2));
         finish_frame($sformatf("rand%0d", f), model_sum(total), n,
                      total > ACC_MAX, !has_last, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_product_accumulator
